// File: rtl/dp_pkg.sv
// Shared types and encodings for the data-processing sequencer and its datapath.
package dp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HLOAD,
        ST_LOAD,
        ST_EXEC,
        ST_WB
    } state_t;

    // ALU operation encodings driven on ALU_op
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;
    localparam logic [2:0] ALU_MOV = 3'b101;
    localparam logic [2:0] ALU_MVN = 3'b110;
    localparam logic [2:0] ALU_CMP = 3'b111;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_t;

    typedef enum logic [1:0] {
        SHIFT_LSL = 2'b00,
        SHIFT_LSR = 2'b01,
        SHIFT_ASR = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_t;

    // Instruction fields captured on the accept cycle (immediate kept separately
    // because its width is a top-level parameter).
    typedef struct packed {
        logic [3:0] cond;
        logic [2:0] alu;
        logic [3:0] rn;
        logic [3:0] rm;
        logic [3:0] rs;
        logic [3:0] rd;
        logic [1:0] shift_op;
        logic [4:0] shift_imm;
        logic       use_imm;
        logic       shift_reg;
        logic       zero_a;
        logic       set_flags;
        logic       write;
    } op_fields_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code check against an NZCV nibble {N,Z,C,V}.
module cond_eval
    import dp_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;

    assign flag_n = nzcv[3];
    assign flag_z = nzcv[2];
    assign flag_c = nzcv[1];
    assign flag_v = nzcv[0];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = flag_z;
            COND_NE: pass = !flag_z;
            COND_CS: pass = flag_c;
            COND_CC: pass = !flag_c;
            COND_MI: pass = flag_n;
            COND_PL: pass = !flag_n;
            COND_VS: pass = flag_v;
            COND_VC: pass = !flag_v;
            COND_HI: pass = flag_c && !flag_z;
            COND_LS: pass = !flag_c || flag_z;
            COND_GE: pass = (flag_n == flag_v);
            COND_LT: pass = (flag_n != flag_v);
            COND_GT: pass = !flag_z && (flag_n == flag_v);
            COND_LE: pass = flag_z || (flag_n != flag_v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/dp_sequencer.sv
// Multi-cycle controller for the register-file/shifter/ALU datapath: IDLE -> LOAD -> EXEC -> WB
// for instructions, IDLE -> HLOAD for host register loads (host wins ties).
module dp_sequencer
    import dp_pkg::*;
#(
    parameter int STATUS_W = 32,
    parameter int IMM_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ld_valid,
    input  logic [3:0]          ld_addr,
    output logic                ld_ready,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [3:0]          op_cond,
    input  logic [2:0]          op_alu,
    input  logic [3:0]          op_rn,
    input  logic [3:0]          op_rm,
    input  logic [3:0]          op_rs,
    input  logic [3:0]          op_rd,
    input  logic [1:0]          op_shift_op,
    input  logic [4:0]          op_shift_imm,
    input  logic [IMM_W-1:0]    op_imm,
    input  logic                op_use_imm,
    input  logic                op_shift_reg,
    input  logic                op_zero_a,
    input  logic                op_set_flags,
    input  logic                op_write,
    input  logic [STATUS_W-1:0] status_in,
    output logic [3:0]          A_addr,
    output logic [3:0]          B_addr,
    output logic [3:0]          shift_addr,
    output logic [3:0]          w_addr,
    output logic                en_A,
    output logic                en_B,
    output logic                en_S,
    output logic                en_status,
    output logic                w_en,
    output logic                sel_A,
    output logic                sel_B,
    output logic                sel_shift,
    output logic                wb_sel,
    output logic [1:0]          shift_op,
    output logic [31:0]         shift_imme,
    output logic [IMM_W-1:0]    imme_data,
    output logic [2:0]          ALU_op,
    output logic                done,
    output logic                skipped
);

    state_t     state;
    state_t     state_next;
    op_fields_t op_q;
    logic [IMM_W-1:0] imm_q;
    logic [3:0] ld_addr_q;
    logic       cond_pass;
    logic       unused_status;

    assign unused_status = ^status_in[STATUS_W-5:0];

    cond_eval u_cond_eval (
        .cond (op_q.cond),
        .nzcv (status_in[STATUS_W-1 -: 4]),
        .pass (cond_pass)
    );

    // State register plus the instruction / host-load latches, written only on accept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            imm_q     <= '0;
            ld_addr_q <= '0;
        end else begin
            state <= state_next;
            if (op_ready) begin
                op_q.cond      <= op_cond;
                op_q.alu       <= op_alu;
                op_q.rn        <= op_rn;
                op_q.rm        <= op_rm;
                op_q.rs        <= op_rs;
                op_q.rd        <= op_rd;
                op_q.shift_op  <= op_shift_op;
                op_q.shift_imm <= op_shift_imm;
                op_q.use_imm   <= op_use_imm;
                op_q.shift_reg <= op_shift_reg;
                op_q.zero_a    <= op_zero_a;
                op_q.set_flags <= op_set_flags;
                op_q.write     <= op_write;
                imm_q          <= op_imm;
            end
            if (ld_ready) begin
                ld_addr_q <= ld_addr;
            end
        end
    end

    // Outputs are forced low while rst_n is low so an abort never leaks a write,
    // a flag update or a handshake on the reset edge itself.
    always_comb begin
        state_next = state;
        ld_ready   = 1'b0;
        op_ready   = 1'b0;
        A_addr     = '0;
        B_addr     = '0;
        shift_addr = '0;
        w_addr     = '0;
        en_A       = 1'b0;
        en_B       = 1'b0;
        en_S       = 1'b0;
        en_status  = 1'b0;
        w_en       = 1'b0;
        sel_A      = 1'b0;
        sel_B      = 1'b0;
        sel_shift  = 1'b0;
        wb_sel     = 1'b0;
        shift_op   = '0;
        shift_imme = '0;
        imme_data  = '0;
        ALU_op     = '0;
        done       = 1'b0;
        skipped    = 1'b0;

        if (rst_n) begin
            // Mux/ALU controls are set up in EXEC and held through WB
            if (state == ST_EXEC || state == ST_WB) begin
                sel_A      = op_q.zero_a;
                sel_B      = op_q.use_imm;
                sel_shift  = op_q.shift_reg;
                shift_op   = op_q.shift_op;
                shift_imme = {27'b0, op_q.shift_imm};
                imme_data  = imm_q;
                ALU_op     = op_q.alu;
            end

            case (state)
                ST_IDLE: begin
                    ld_ready = ld_valid;
                    op_ready = op_valid && !ld_valid;
                    if (ld_valid) begin
                        state_next = ST_HLOAD;
                    end else if (op_valid) begin
                        state_next = ST_LOAD;
                    end
                end
                ST_HLOAD: begin
                    w_en       = 1'b1;
                    wb_sel     = 1'b1;
                    w_addr     = ld_addr_q;
                    state_next = ST_IDLE;
                end
                ST_LOAD: begin
                    if (cond_pass) begin
                        en_A       = 1'b1;
                        en_B       = 1'b1;
                        en_S       = 1'b1;
                        A_addr     = op_q.rn;
                        B_addr     = op_q.rm;
                        shift_addr = op_q.rs;
                        state_next = ST_EXEC;
                    end else begin
                        done       = 1'b1;
                        skipped    = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    en_status  = op_q.set_flags;
                    state_next = ST_WB;
                end
                ST_WB: begin
                    w_en       = op_q.write;
                    w_addr     = op_q.rd;
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dp_sequencer.sv
// Directed self-checking bench for dp_sequencer: host loads, executed/skipped ops,
// host priority and mid-sequence reset.
module tb_dp_sequencer;
    import dp_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        ld_valid;
    logic [3:0]  ld_addr;
    logic        ld_ready;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  op_cond;
    logic [2:0]  op_alu;
    logic [3:0]  op_rn;
    logic [3:0]  op_rm;
    logic [3:0]  op_rs;
    logic [3:0]  op_rd;
    logic [1:0]  op_shift_op;
    logic [4:0]  op_shift_imm;
    logic [31:0] op_imm;
    logic        op_use_imm;
    logic        op_shift_reg;
    logic        op_zero_a;
    logic        op_set_flags;
    logic        op_write;
    logic [31:0] status_in;
    logic [3:0]  A_addr;
    logic [3:0]  B_addr;
    logic [3:0]  shift_addr;
    logic [3:0]  w_addr;
    logic        en_A;
    logic        en_B;
    logic        en_S;
    logic        en_status;
    logic        w_en;
    logic        sel_A;
    logic        sel_B;
    logic        sel_shift;
    logic        wb_sel;
    logic [1:0]  shift_op;
    logic [31:0] shift_imme;
    logic [31:0] imme_data;
    logic [2:0]  ALU_op;
    logic        done;
    logic        skipped;

    int checks = 0;
    int errors = 0;

    dp_sequencer #(.STATUS_W(32), .IMM_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_ready(ld_ready),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_cond(op_cond), .op_alu(op_alu),
        .op_rn(op_rn), .op_rm(op_rm), .op_rs(op_rs), .op_rd(op_rd),
        .op_shift_op(op_shift_op), .op_shift_imm(op_shift_imm), .op_imm(op_imm),
        .op_use_imm(op_use_imm), .op_shift_reg(op_shift_reg), .op_zero_a(op_zero_a),
        .op_set_flags(op_set_flags), .op_write(op_write),
        .status_in(status_in),
        .A_addr(A_addr), .B_addr(B_addr), .shift_addr(shift_addr), .w_addr(w_addr),
        .en_A(en_A), .en_B(en_B), .en_S(en_S), .en_status(en_status), .w_en(w_en),
        .sel_A(sel_A), .sel_B(sel_B), .sel_shift(sel_shift), .wb_sel(wb_sel),
        .shift_op(shift_op), .shift_imme(shift_imme), .imme_data(imme_data),
        .ALU_op(ALU_op), .done(done), .skipped(skipped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are then driven 2 time units after the edge
    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic clear_op;
        op_valid     = 1'b0;
        op_cond      = 4'h0;
        op_alu       = 3'h0;
        op_rn        = 4'h0;
        op_rm        = 4'h0;
        op_rs        = 4'h0;
        op_rd        = 4'h0;
        op_shift_op  = 2'h0;
        op_shift_imm = 5'h0;
        op_imm       = 32'h0;
        op_use_imm   = 1'b0;
        op_shift_reg = 1'b0;
        op_zero_a    = 1'b0;
        op_set_flags = 1'b0;
        op_write     = 1'b0;
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        ld_valid = 1'b1;
        ld_addr  = 4'h5;
        clear_op();
        op_valid  = 1'b1;
        op_cond   = COND_AL;
        status_in = 32'h0;
        #1;
        checks++;
        if ({ld_ready, op_ready, w_en, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_handshake: got %b expected 0000", {ld_ready, op_ready, w_en, done});
        end
        step();
        step();
        ld_valid = 1'b0;
        op_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        checks++;
        if ({en_A, en_B, en_S, en_status, w_en, wb_sel, done, skipped, w_addr, ALU_op} !== 15'h0) begin
            errors++;
            $display("FAIL reset_idle_outputs: got %h expected 0",
                     {en_A, en_B, en_S, en_status, w_en, wb_sel, done, skipped, w_addr, ALU_op});
        end
    endtask

    task automatic test_host_load;
        for (int i = 0; i < 16; i++) begin
            step();
            ld_valid = 1'b1;
            ld_addr  = i[3:0];
            #1;
            checks++;
            if ({ld_ready, w_en} !== 2'b10) begin
                errors++;
                $display("FAIL hload_accept[%0d]: got %b expected 10", i, {ld_ready, w_en});
            end
            step();
            ld_valid = 1'b0;
            ld_addr  = 4'hF - i[3:0];
            #1;
            checks++;
            if ({w_en, wb_sel, w_addr, ld_ready, done} !== {2'b11, i[3:0], 2'b00}) begin
                errors++;
                $display("FAIL hload_write[%0d]: got %b expected %b", i,
                         {w_en, wb_sel, w_addr, ld_ready, done}, {2'b11, i[3:0], 2'b00});
            end
        end
    endtask

    task automatic test_add;
        step();
        clear_op();
        op_valid     = 1'b1;
        op_cond      = COND_AL;
        op_alu       = ALU_ADD;
        op_rn        = 4'd1;
        op_rm        = 4'd2;
        op_rs        = 4'd1;
        op_rd        = 4'd3;
        op_shift_op  = SHIFT_LSL;
        op_shift_reg = 1'b1;
        op_write     = 1'b1;
        #1;
        checks++;
        if (op_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_accept: op_ready got %b expected 1", op_ready);
        end
        step();
        clear_op();
        op_rd = 4'hE;
        #1;
        checks++;
        if ({en_A, en_B, en_S, A_addr, B_addr, shift_addr, done} !== {3'b111, 4'd1, 4'd2, 4'd1, 1'b0}) begin
            errors++;
            $display("FAIL add_load: got %h expected %h",
                     {en_A, en_B, en_S, A_addr, B_addr, shift_addr, done}, {3'b111, 4'd1, 4'd2, 4'd1, 1'b0});
        end
        step();
        #1;
        checks++;
        if ({en_A, en_B, en_S, sel_A, sel_B, sel_shift, shift_op, ALU_op, en_status, w_en, done}
                !== {3'b000, 3'b001, 2'b00, 3'b000, 3'b000}) begin
            errors++;
            $display("FAIL add_exec: got %b expected 00000100000000",
                     {en_A, en_B, en_S, sel_A, sel_B, sel_shift, shift_op, ALU_op, en_status, w_en, done});
        end
        step();
        #1;
        checks++;
        if ({w_en, wb_sel, w_addr, done, skipped, sel_shift, en_status} !== {2'b10, 4'd3, 4'b1010}) begin
            errors++;
            $display("FAIL add_wb: got %b expected 1000111010",
                     {w_en, wb_sel, w_addr, done, skipped, sel_shift, en_status});
        end
        step();
        #1;
        checks++;
        if ({done, w_en} !== 2'b00) begin
            errors++;
            $display("FAIL add_retire: got %b expected 00", {done, w_en});
        end
    endtask

    task automatic test_sub_flags;
        clear_op();
        op_valid     = 1'b1;
        op_cond      = COND_AL;
        op_alu       = ALU_SUB;
        op_rd        = 4'd4;
        op_imm       = 32'd12;
        op_use_imm   = 1'b1;
        op_zero_a    = 1'b1;
        op_set_flags = 1'b1;
        op_write     = 1'b1;
        step();
        clear_op();
        #1;
        checks++;
        if ({en_status, en_A} !== 2'b01) begin
            errors++;
            $display("FAIL sub_load: got %b expected 01", {en_status, en_A});
        end
        step();
        #1;
        checks++;
        if ({en_status, sel_A, sel_B, ALU_op, imme_data} !== {3'b111, 3'b001, 32'd12}) begin
            errors++;
            $display("FAIL sub_exec: got %h expected %h",
                     {en_status, sel_A, sel_B, ALU_op, imme_data}, {3'b111, 3'b001, 32'd12});
        end
        step();
        status_in = 32'h8000_0000;
        #1;
        checks++;
        if ({en_status, w_en, w_addr, done} !== {2'b01, 4'd4, 1'b1}) begin
            errors++;
            $display("FAIL sub_wb: got %b expected 0101001", {en_status, w_en, w_addr, done});
        end
        // A MI op now sees the N flag left by the subtraction
        step();
        op_valid = 1'b1;
        op_cond  = COND_MI;
        op_rn    = 4'd7;
        step();
        clear_op();
        #1;
        checks++;
        if ({en_A, A_addr, skipped} !== {1'b1, 4'd7, 1'b0}) begin
            errors++;
            $display("FAIL mi_after_flags: got %b expected 101110", {en_A, A_addr, skipped});
        end
        step();
        step();
        step();
    endtask

    typedef struct {
        logic [3:0] cond;
        logic [3:0] nzcv;
        logic       pass;
    } cond_vec_t;

    task automatic test_conditions;
        cond_vec_t vecs[12];
        vecs[0]  = '{COND_EQ, 4'b0000, 1'b0};
        vecs[1]  = '{COND_NE, 4'b0000, 1'b1};
        vecs[2]  = '{COND_HI, 4'b0010, 1'b1};
        vecs[3]  = '{COND_LS, 4'b0010, 1'b0};
        vecs[4]  = '{COND_GE, 4'b1001, 1'b1};
        vecs[5]  = '{COND_LT, 4'b1000, 1'b1};
        vecs[6]  = '{COND_GT, 4'b0100, 1'b0};
        vecs[7]  = '{COND_LE, 4'b0100, 1'b1};
        vecs[8]  = '{COND_NV, 4'b0000, 1'b0};
        vecs[9]  = '{COND_CC, 4'b0010, 1'b0};
        vecs[10] = '{COND_VS, 4'b0001, 1'b1};
        vecs[11] = '{COND_PL, 4'b1000, 1'b0};
        for (int i = 0; i < 12; i++) begin
            clear_op();
            status_in    = {vecs[i].nzcv, 28'h0};
            op_valid     = 1'b1;
            op_cond      = vecs[i].cond;
            op_set_flags = 1'b1;
            op_write     = 1'b1;
            step();
            clear_op();
            #1;
            checks++;
            if ({done, skipped, en_A, en_B, en_S, en_status, w_en}
                    !== {!vecs[i].pass, !vecs[i].pass, {3{vecs[i].pass}}, 2'b00}) begin
                errors++;
                $display("FAIL cond_load[%0d]: got %b expected %b", i,
                         {done, skipped, en_A, en_B, en_S, en_status, w_en},
                         {!vecs[i].pass, !vecs[i].pass, {3{vecs[i].pass}}, 2'b00});
            end
            if (vecs[i].pass) begin
                step();
                step();
                #1;
                checks++;
                if ({done, skipped, w_en} !== 3'b101) begin
                    errors++;
                    $display("FAIL cond_wb[%0d]: got %b expected 101", i, {done, skipped, w_en});
                end
            end
            step();
        end
        status_in = 32'h0;
    endtask

    task automatic test_priority;
        clear_op();
        ld_valid = 1'b1;
        ld_addr  = 4'd9;
        op_valid = 1'b1;
        op_cond  = COND_AL;
        op_rd    = 4'd6;
        op_write = 1'b1;
        #1;
        checks++;
        if ({ld_ready, op_ready} !== 2'b10) begin
            errors++;
            $display("FAIL prio_idle: got %b expected 10", {ld_ready, op_ready});
        end
        step();
        ld_valid = 1'b0;
        #1;
        checks++;
        if ({op_ready, w_en, wb_sel, w_addr} !== {3'b011, 4'd9}) begin
            errors++;
            $display("FAIL prio_hload: got %b expected 0111001", {op_ready, w_en, wb_sel, w_addr});
        end
        step();
        #1;
        checks++;
        if (op_ready !== 1'b1) begin
            errors++;
            $display("FAIL prio_op_accept: op_ready got %b expected 1", op_ready);
        end
        step();
        clear_op();
        step();
        step();
        #1;
        checks++;
        if ({done, w_en, w_addr} !== {2'b11, 4'd6}) begin
            errors++;
            $display("FAIL prio_op_wb: got %b expected 110110", {done, w_en, w_addr});
        end
        step();
    endtask

    task automatic test_reset_midop;
        clear_op();
        op_valid     = 1'b1;
        op_cond      = COND_AL;
        op_rd        = 4'd8;
        op_set_flags = 1'b1;
        op_write     = 1'b1;
        step();
        clear_op();
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({en_status, w_en, done} !== 3'b000) begin
            errors++;
            $display("FAIL midreset_exec: got %b expected 000", {en_status, w_en, done});
        end
        step();
        rst_n = 1'b1;
        #1;
        checks++;
        if ({en_status, w_en, done, sel_B, w_addr} !== 8'h00) begin
            errors++;
            $display("FAIL midreset_after: got %b expected 00000000", {en_status, w_en, done, sel_B, w_addr});
        end
        step();
        #1;
        checks++;
        if ({w_en, done} !== 2'b00) begin
            errors++;
            $display("FAIL midreset_no_wb: got %b expected 00", {w_en, done});
        end
        op_valid = 1'b1;
        op_cond  = COND_AL;
        op_rd    = 4'd2;
        op_write = 1'b1;
        step();
        clear_op();
        step();
        step();
        #1;
        checks++;
        if ({done, skipped, w_en, w_addr} !== {3'b101, 4'd2}) begin
            errors++;
            $display("FAIL midreset_recover: got %b expected 1010010", {done, skipped, w_en, w_addr});
        end
        step();
    endtask

    initial begin
        test_reset();
        test_host_load();
        test_add();
        test_sub_flags();
        test_conditions();
        test_priority();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
